// File: rtl/ui_draw_scheduler.sv
// ui_draw_scheduler: round-robin scheduler that hands the VGA pixel port to
// one of four drawing units at a time (IDLE -> LAUNCH -> DRAW -> RELEASE).
// Optional build macro SCHED_WATCHDOG_EN adds a per-unit drawing watchdog
// of TIMEOUT_CYCLES clocks.
module ui_draw_scheduler #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [31:0] unit_x,
    input  logic [27:0] unit_y,
    input  logic [11:0] unit_color,
    input  logic [3:0]  unit_we,
    input  logic [3:0]  unit_done,
    output logic [3:0]  run,
    output logic [3:0]  start,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  color,
    output logic        plot,
    output logic [1:0]  gnt_id,
    output logic        busy,
    output logic        timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        DRAW    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  ptr;
    logic [1:0]  pick;
    logic        pick_vld;
    logic [1:0]  idx;
    logic [3:0]  gnt_onehot;
    logic [7:0]  sel_x;
    logic [6:0]  sel_y;
    logic [2:0]  sel_c;
    logic        plot_q;
    logic        wd_expire;

    // Round-robin search: first requesting unit at ptr, ptr+1, ... (mod 4)
    always_comb begin
        pick     = ptr;
        pick_vld = 1'b0;
        idx      = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            idx = ptr + k[1:0];
            if (!pick_vld && req[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    // Next-state logic; only the granted unit's done flag is observed
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_vld) state_nxt = LAUNCH;
            LAUNCH:  state_nxt = DRAW;
            DRAW:    if (unit_done[gnt_id] || wd_expire) state_nxt = RELEASE;
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, grant index and round-robin pointer registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            ptr    <= '0;
            gnt_id <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && pick_vld) gnt_id <= pick;
            if (state == RELEASE)          ptr    <= gnt_id + 2'd1;
        end
    end

    // Granted unit's pixel fields
    always_comb begin
        sel_x = '0;
        sel_y = '0;
        sel_c = '0;
        case (gnt_id)
            2'd0: begin sel_x = unit_x[7:0];   sel_y = unit_y[6:0];   sel_c = unit_color[2:0];  end
            2'd1: begin sel_x = unit_x[15:8];  sel_y = unit_y[13:7];  sel_c = unit_color[5:3];  end
            2'd2: begin sel_x = unit_x[23:16]; sel_y = unit_y[20:14]; sel_c = unit_color[8:6];  end
            default: begin sel_x = unit_x[31:24]; sel_y = unit_y[27:21]; sel_c = unit_color[11:9]; end
        endcase
    end

    // Pixel datapath: capture granted unit while drawing, hold otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x      <= '0;
            y      <= '0;
            color  <= '0;
            plot_q <= 1'b0;
        end else if (state == DRAW) begin
            x      <= sel_x;
            y      <= sel_y;
            color  <= sel_c;
            plot_q <= unit_we[gnt_id];
        end else begin
            plot_q <= 1'b0;
        end
    end

    // Unit handshake outputs decoded from state so reset drops them at once
    always_comb begin
        gnt_onehot = 4'b0001 << gnt_id;
        run        = (state == LAUNCH || state == DRAW) ? gnt_onehot : '0;
        start      = (state == LAUNCH) ? gnt_onehot : '0;
        busy       = (state != IDLE);
        plot       = plot_q && (state == DRAW);
    end

`ifdef SCHED_WATCHDOG_EN
    logic [23:0] wd_cnt;

    assign wd_expire = (wd_cnt == TIMEOUT_CYCLES - 24'd1);

    // Watchdog: cleared on launch, counts draw cycles, flags a forced release
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            if (state == LAUNCH)    wd_cnt <= '0;
            else if (state == DRAW) wd_cnt <= wd_cnt + 24'd1;
            timeout <= (state == DRAW) && !unit_done[gnt_id] && wd_expire;
        end
    end
`else
    // No watchdog: limit referenced only so the parameter stays in the interface
    assign wd_expire = 1'b0 && (TIMEOUT_CYCLES != '0);
    assign timeout   = 1'b0;
`endif

endmodule

// File: doc/ui_draw_scheduler.md
UI_DRAW_SCHEDULER -- requirements
Module: ui_draw_scheduler

Interface
REQ-001 SHALL provide parameter TIMEOUT_CYCLES, default 24'd12_000_000, watchdog limit in clk cycles per drawing unit.
REQ-002 SHALL provide port clk, input, 1, single system clock; all state on its rising edge.
REQ-003 SHALL provide port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL provide port req, input, 4, per-unit draw request, level.
REQ-005 SHALL provide port unit_x, input, 32, packed 4x8 x coords, unit i at [8i+7:8i].
REQ-006 SHALL provide port unit_y, input, 28, packed 4x7 y coords, unit i at [7i+6:7i].
REQ-007 SHALL provide port unit_color, input, 12, packed 4x3 colours, unit i at [3i+2:3i].
REQ-008 SHALL provide port unit_we, input, 4, per-unit pixel write enable.
REQ-009 SHALL provide port unit_done, input, 4, per-unit drawing-complete flag (level).
REQ-010 SHALL provide port run, output, 4, per-unit active-low datapath hold (1 = unit may run).
REQ-011 SHALL provide port start, output, 4, per-unit one-cycle enable pulse.
REQ-012 SHALL provide ports x (output, 8), y (output, 7), color (output, 3), plot (output, 1) to the VGA adapter.
REQ-013 SHALL provide ports gnt_id (output, 2) current/last grant index, busy (output, 1), timeout (output, 1).

Function
REQ-014 SHALL implement FSM states IDLE, LAUNCH, DRAW, RELEASE, 2-bit registered state.
REQ-015 IDLE: if req!=0, SHALL grant the first set bit searching ptr, ptr+1, ... mod 4, register gnt_id, go LAUNCH next cycle; req==0 stays IDLE.
REQ-016 LAUNCH: SHALL hold exactly one cycle with run[gnt_id]=1, start[gnt_id]=1, then DRAW.
REQ-017 DRAW: SHALL keep run[gnt_id]=1, start=0; all non-granted run bits 0 in every state.
REQ-018 DRAW: x, y, color SHALL be registered copies of granted unit's fields, 1-cycle latency; plot = registered unit_we[gnt_id] while in DRAW, else 0.
REQ-019 DRAW: SHALL go RELEASE on cycle after unit_done[gnt_id]=1 is sampled; unit_done sampled only in DRAW.
REQ-020 RELEASE: SHALL hold one cycle with run=0, plot=0, ptr <= gnt_id+1 mod 4, then IDLE.
REQ-021 unit_we/unit_done from non-granted units SHALL never affect plot or state.
REQ-022 Deassertion of req[gnt_id] during LAUNCH/DRAW SHALL NOT abort; grant held to done (or timeout).
REQ-023 Back-to-back: done sampled cycle N -> RELEASE N+1, IDLE N+2, LAUNCH of next unit N+3.
REQ-024 busy SHALL equal (state != IDLE); x/y/color hold last value outside DRAW.

Reset
REQ-025 reset=1 SHALL immediately force state IDLE, ptr 0, gnt_id 0, run 0, start 0, x 0, y 0, color 0, plot 0, timeout 0, watchdog counter 0, independent of clk.
REQ-026 reset mid-DRAW SHALL drop run and plot asynchronously; first grant after release of reset follows REQ-015 from ptr 0.

Configuration
REQ-027 Macro SCHED_WATCHDOG_EN defined: 24-bit counter clears on LAUNCH, increments each DRAW cycle; at TIMEOUT_CYCLES-1 without done SHALL go RELEASE with timeout=1 for that RELEASE cycle only; ptr advances as normal.
REQ-028 Macro SCHED_WATCHDOG_EN undefined: no counter; timeout tied 0; DRAW waits indefinitely for done.

Verification
REQ-029 reset, req=4'b0001, unit0 asserts done after 20 DRAW cycles -> start[0] pulse 1 cycle, run[0]=1 for 21 cycles, then RELEASE, busy low 2 cycles after done sampled.
REQ-030 req=4'b1111 held, each unit done after 5 cycles -> grant order 0,1,2,3,0; LAUNCH gaps exactly 3 cycles after each done.
REQ-031 granted unit2, unit_we=1 with (x,y,color)=(8'd70,7'd60,3'b010), unit1 unit_we=1 simultaneously -> plot=1 next cycle with unit2 values only.
REQ-032 reset pulsed mid-DRAW of unit3 -> run, plot, busy 0 in same cycle; next req=4'b1000 still granted from ptr 0 search.
REQ-033 SCHED_WATCHDOG_EN, TIMEOUT_CYCLES=16, unit0 never done -> RELEASE after 16 DRAW cycles, timeout=1 one cycle, next grant to unit1 when req=4'b0011.
REQ-034 unit_done[1]=1 while unit0 granted -> ignored; unit0 stays in DRAW.
